// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty scheduler: duty width,
// default limits and the ramp FSM state encoding.
package pwm_pkg;

  localparam int DUTY_W         = 4;
  localparam int DUTY_MAX_DEF   = 10;
  localparam int DUTY_RESET_DEF = 5;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic duty_t clamp_duty(input duty_t value, input duty_t limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Ramp step interval counter: counts enabled cycles and raises tick on
// every STEP_CYCLES-th one; clear forces it back to zero.
module pwm_step_timer #(
  parameter int STEP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_duty_sched.sv
// PWM duty scheduler: host-requested ramps and manual single steps.
// Define PWM_SCHED_SOFTSTART_EN to ramp up from 0 to DUTY_RESET after reset.
module pwm_duty_sched
  import pwm_pkg::*;
#(
  parameter int DUTY_MAX    = DUTY_MAX_DEF,
  parameter int DUTY_RESET  = DUTY_RESET_DEF,
  parameter int STEP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              man_inc,
  input  logic              man_dec,
  input  logic              host_valid,
  input  logic [DUTY_W-1:0] host_target,
  input  logic              host_abort,
  output logic              host_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              step_inc,
  output logic              step_dec,
  output logic              busy,
  output logic              done
);

  localparam duty_t DMAX = duty_t'(DUTY_MAX);
  localparam duty_t DRST = duty_t'(DUTY_RESET);

`ifdef PWM_SCHED_SOFTSTART_EN
  localparam state_e STATE_INIT = ST_RAMP;
  localparam duty_t  DUTY_INIT  = '0;
`else
  localparam state_e STATE_INIT = ST_IDLE;
  localparam duty_t  DUTY_INIT  = DRST;
`endif

  state_e state_q, state_d;
  duty_t  duty_q, duty_d;
  duty_t  target_q, target_d;
  logic   step_inc_q, step_inc_d;
  logic   step_dec_q, step_dec_d;
  logic   tick;
  logic   idle_en;

  pwm_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst_n),
    .clear  (state_q != ST_RAMP),
    .enable ((state_q == ST_RAMP) && ena),
    .tick   (tick)
  );

  assign idle_en = (state_q == ST_IDLE) && ena;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_inc_d = 1'b0;
    step_dec_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_en && host_valid) begin
          // The host request wins over any manual step in the same cycle.
          target_d = clamp_duty(host_target, DMAX);
          state_d  = (target_d == duty_q) ? ST_DONE : ST_RAMP;
        end else if (idle_en && man_inc && !man_dec && duty_q < DMAX) begin
          duty_d     = duty_q + 1'b1;
          step_inc_d = 1'b1;
        end else if (idle_en && man_dec && !man_inc && duty_q != '0) begin
          duty_d     = duty_q - 1'b1;
          step_dec_d = 1'b1;
        end
      end
      ST_RAMP: begin
        // Completion is recognised the cycle after the final step lands.
        if (host_abort || duty_q == target_q) begin
          state_d = ST_DONE;
        end else if (tick) begin
          if (duty_q < target_q) begin
            duty_d     = duty_q + 1'b1;
            step_inc_d = 1'b1;
          end else begin
            duty_d     = duty_q - 1'b1;
            step_dec_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= STATE_INIT;
      duty_q     <= DUTY_INIT;
      target_q   <= DRST;
      step_inc_q <= 1'b0;
      step_dec_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_inc_q <= step_inc_d;
      step_dec_q <= step_dec_d;
    end
  end

  // Status outputs are forced low for the whole time reset is held.
  assign host_ready = idle_en && !rst_n;
  assign busy       = (state_q == ST_RAMP) && !rst_n;
  assign done       = (state_q == ST_DONE) && !rst_n;
  assign duty       = duty_q;
  assign step_inc   = step_inc_q;
  assign step_dec   = step_dec_q;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Self-checking bench for pwm_duty_sched: a ramp-level reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_pwm_duty_sched;

  localparam int DMAX = 10;
  localparam int DRST = 5;
  localparam int SC   = 16;

  logic       clk = 1'b0;
  logic       rst_n, ena, man_inc, man_dec, host_valid, host_abort;
  logic [3:0] host_target;
  logic       host_ready, step_inc, step_dec, busy, done;
  logic [3:0] duty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 idle, 1 ramping, 2 done.
  int m_phase, m_duty, m_start, m_target, m_cnt;
  bit m_inc, m_dec;

  pwm_duty_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .man_inc     (man_inc),
    .man_dec     (man_dec),
    .host_valid  (host_valid),
    .host_target (host_target),
    .host_abort  (host_abort),
    .host_ready  (host_ready),
    .duty        (duty),
    .step_inc    (step_inc),
    .step_dec    (step_dec),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Duty along a ramp follows from the number of enabled cycles since acceptance.
  always @(posedge clk) begin
    int t, steps;
    m_inc = 1'b0;
    m_dec = 1'b0;
    if (rst_n) begin
      m_phase = 0;
      m_duty  = DRST;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: begin
          if (ena && host_valid) begin
            t        = (int'(host_target) > DMAX) ? DMAX : int'(host_target);
            m_start  = m_duty;
            m_target = t;
            m_cnt    = 0;
            m_phase  = (t == m_duty) ? 2 : 1;
          end else if (ena && man_inc && !man_dec && m_duty < DMAX) begin
            m_duty++;
            m_inc = 1'b1;
          end else if (ena && man_dec && !man_inc && m_duty > 0) begin
            m_duty--;
            m_dec = 1'b1;
          end
        end
        1: begin
          if (host_abort || m_duty == m_target) begin
            m_phase = 2;
          end else if (ena) begin
            m_cnt++;
            if (m_cnt % SC == 0) begin
              steps = m_cnt / SC;
              if (m_target > m_start) begin
                m_duty = m_start + steps;
                m_inc  = 1'b1;
              end else begin
                m_duty = m_start - steps;
                m_dec  = 1'b1;
              end
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("duty",       int'(duty),       m_duty);
      chk("step_inc",   int'(step_inc),   int'(m_inc));
      chk("step_dec",   int'(step_dec),   int'(m_dec));
      chk("busy",       int'(busy),       int'(m_phase == 1 && !rst_n));
      chk("done",       int'(done),       int'(m_phase == 2 && !rst_n));
      chk("host_ready", int'(host_ready), int'(m_phase == 0 && ena && !rst_n));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = done;
    end
    chk("wait_done", int'(seen), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  task automatic host_req(input int target);
    host_valid  = 1'b1;
    host_target = 4'(target);
    step();
    host_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; man_inc = 1'b0; man_dec = 1'b0;
    host_valid = 1'b0; host_target = '0; host_abort = 1'b0;
    step();
    chk_en = 1'b1;
    step_n(2);
    chk("rst_duty", int'(duty), 5);
    chk("rst_ready", int'(host_ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b0;
    step();
    chk("idle_ready", int'(host_ready), 1);

    // Ramp 5 -> 8 with 16-cycle spacing.
    host_req(8);
    chk("r8_busy", int'(busy), 1);
    step_n(15);
    chk("r8_hold5", int'(duty), 5);
    step();
    chk("r8_duty6", int'(duty), 6);
    chk("r8_inc6", int'(step_inc), 1);
    step();
    chk("r8_inc_pulse", int'(step_inc), 0);
    step_n(15);
    chk("r8_duty7", int'(duty), 7);
    step_n(16);
    chk("r8_duty8", int'(duty), 8);
    chk("r8_not_done", int'(done), 0);
    step();
    chk("r8_done", int'(done), 1);
    step();
    chk("r8_done_pulse", int'(done), 0);
    chk("r8_ready", int'(host_ready), 1);

    // Clamp to DUTY_MAX, then manual increment at the limit is ignored.
    host_req(14);
    wait_done(100);
    chk("clamp_duty", int'(duty), 10);
    step();
    man_inc = 1'b1;
    step();
    man_inc = 1'b0;
    chk("max_inc_ignored", int'(duty), 10);
    chk("max_no_pulse", int'(step_inc), 0);

    // Ramp down aborted after the second step.
    do_reset();
    host_req(0);
    step_n(32);
    chk("abort_pre", int'(duty), 3);
    host_abort = 1'b1;
    step();
    host_abort = 1'b0;
    chk("abort_done", int'(done), 1);
    chk("abort_hold", int'(duty), 3);
    step();
    chk("abort_ready", int'(host_ready), 1);
    chk("abort_idle_duty", int'(duty), 3);

    // Host beats a simultaneous manual request; conflicting manual bits are ignored.
    do_reset();
    man_inc = 1'b1;
    host_req(5);
    man_inc = 1'b0;
    chk("host_wins_duty", int'(duty), 5);
    chk("host_wins_done", int'(done), 1);
    step();
    man_inc = 1'b1; man_dec = 1'b1;
    step();
    man_inc = 1'b0; man_dec = 1'b0;
    chk("both_ignored", int'(duty), 5);
    man_inc = 1'b1;
    step();
    man_inc = 1'b0;
    chk("man_inc", int'(duty), 6);
    man_dec = 1'b1;
    step();
    man_dec = 1'b0;
    chk("man_dec", int'(duty), 5);
    chk("man_dec_pulse", int'(step_dec), 1);

    // Enable gap freezes the ramp; reset mid-ramp gives no done pulse.
    host_req(8);
    step_n(20);
    chk("gap_pre", int'(duty), 6);
    ena = 1'b0;
    step_n(40);
    chk("gap_hold", int'(duty), 6);
    chk("gap_busy", int'(busy), 1);
    ena = 1'b1;
    step_n(11);
    chk("gap_resume_wait", int'(duty), 6);
    step();
    chk("gap_resume_step", int'(duty), 7);
    step_n(5);
    rst_n = 1'b1;
    step();
    chk("midrst_duty", int'(duty), 5);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    rst_n = 1'b0;
    step();
    chk("midrst_no_done", int'(done), 0);
    chk("midrst_ready", int'(host_ready), 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n       = ($urandom_range(0, 499) == 0);
      ena         = ($urandom_range(0, 7) != 0);
      host_valid  = ($urandom_range(0, 11) == 0);
      host_target = 4'($urandom_range(0, 15));
      host_abort  = ($urandom_range(0, 199) == 0);
      man_inc     = ($urandom_range(0, 3) == 0);
      man_dec     = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sched.md
PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

Interface
REQ-001 SHALL have parameter DUTY_MAX, default 10: upper duty limit, in tenths.
REQ-002 SHALL have parameter DUTY_RESET, default 5: duty value loaded at reset.
REQ-003 SHALL have parameter STEP_CYCLES, default 16: clk cycles per ramp step (>=1).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- ena  in  1  global enable.
- man_inc  in  1  manual single-step-up request.
- man_dec  in  1  manual single-step-down request.
- host_valid  in  1  host ramp request valid.
- host_target  in  4  host target duty.
- host_abort  in  1  stop the active ramp.
- host_ready  out  1  host request may be accepted.
- duty  out  4  duty value driven to the PWM datapath.
- step_inc  out  1  one-cycle pulse on each duty increment.
- step_dec  out  1  one-cycle pulse on each duty decrement.
- busy  out  1  ramp in progress.
- done  out  1  one-cycle pulse at ramp completion or abort.

Function
REQ-005 SHALL implement FSM states IDLE, RAMP and DONE.
REQ-006 host_ready SHALL be 1 only in IDLE with ena=1; a request is accepted on a cycle with host_valid & host_ready.
REQ-007 On acceptance, target SHALL be min(host_target, DUTY_MAX); if target==duty, go to DONE, otherwise go to RAMP with the step timer cleared.
REQ-008 In RAMP, every STEP_CYCLES-th enabled cycle, duty SHALL move one count toward target, with step_inc/step_dec high in that same cycle (registered, visible with the new duty).
REQ-009 When duty reaches target, the FSM SHALL go to DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-010 busy SHALL equal (state==RAMP).
REQ-011 Manual requests SHALL be honoured only in IDLE with ena=1 and no host acceptance in the same cycle; the host wins.
REQ-012 man_inc at duty==DUTY_MAX, man_dec at duty==0, and man_inc & man_dec together SHALL be ignored.
REQ-013 An honoured manual step SHALL change duty by one on the next edge, pulse step_inc/step_dec, and leave the FSM in IDLE.
REQ-014 With ena=0 in RAMP, the timer and duty SHALL freeze; the ramp resumes when ena returns.
REQ-015 host_abort in RAMP SHALL hold the current duty and go to DONE; host_abort in other states SHALL be ignored.
REQ-016 duty SHALL never leave [0, DUTY_MAX]; no wrap-around.

Reset
REQ-017 While rst_n=1: state=IDLE, duty=DUTY_RESET, timer=0, and host_ready, step_inc, step_dec, busy and done all 0.
REQ-018 Reset mid-ramp SHALL discard the target with no done pulse.

Configuration
REQ-019 Macro PWM_SCHED_SOFTSTART_EN: when defined, reset SHALL load duty=0 and, on reset release, auto-enter RAMP toward DUTY_RESET (host_ready=0 until done). When undefined, reset loads DUTY_RESET directly and starts in IDLE.

Structure
REQ-020 Package pwm_pkg SHALL hold DUTY_W=4, the default DUTY_MAX and DUTY_RESET values, and the FSM state typedef.
REQ-021 The step interval counter SHALL be a sub-module pwm_step_timer with clear, enable and a tick output.

Verification
REQ-022 Reset, then host_target=8 accepted: duty goes 5→6→7→8 at 16-cycle intervals, three step_inc pulses, done 1 cycle after duty=8.
REQ-023 host_target=14: clamped to 10, ramp ends at duty=10; a following man_inc is ignored.
REQ-024 Ramp 5→0 with host_abort asserted after the 2nd step: duty holds 3, done pulses, then IDLE with host_ready=1.
REQ-025 In IDLE, man_inc and host_valid in the same cycle: the host is accepted, duty is unchanged by the manual request; man_inc & man_dec together leave duty=5.
REQ-026 ena=0 for 40 cycles mid-ramp: no steps occur and the timer holds; the remaining steps resume at the same spacing; rst_n mid-ramp gives duty=5, IDLE, no done pulse.
